// File: rtl/cpuf_pkg.sv
// Shared opcode, state and ALU-op encodings for the accumulator CPU sequencer.
package cpuf_pkg;

  // Opcode encodings (upper OP_W bits of the instruction word)
  localparam logic [3:0] OP_LDA = 4'b1000;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Sequencer states, kept as plain constants so older blocks can share the encoding
  typedef logic [3:0] state_t;
  localparam state_t ST_FETCH_ADDR = 4'd0;
  localparam state_t ST_FETCH_MEM  = 4'd1;
  localparam state_t ST_DECODE     = 4'd2;
  localparam state_t ST_EXEC_ADDR  = 4'd3;
  localparam state_t ST_EXEC_MEM   = 4'd4;
  localparam state_t ST_LOAD       = 4'd5;
  localparam state_t ST_ALU        = 4'd6;
  localparam state_t ST_JUMP       = 4'd7;
  localparam state_t ST_HALT       = 4'd8;
  localparam state_t ST_FAULT      = 4'd9;

  // ALU operation select driven onto alu_op
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode classifier: splits an opcode into the few flags the sequencer branches on.
module op_decoder
  import cpuf_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] opcode,
  output logic            is_load,
  output logic            is_ldb,
  output logic            is_alu,
  output logic [1:0]      alu_op,
  output logic            is_jmp,
  output logic            is_hlt
);

  // Anything not matched below falls through as a NOP (all flags low)
  always_comb begin
    is_load = 1'b0;
    is_ldb  = 1'b0;
    is_alu  = 1'b0;
    alu_op  = ALU_ADD;
    is_jmp  = 1'b0;
    is_hlt  = 1'b0;
    if (opcode == OP_W'(OP_LDA)) begin
      is_load = 1'b1;
    end else if (opcode == OP_W'(OP_LDB)) begin
      is_load = 1'b1;
      is_ldb  = 1'b1;
    end else if (opcode == OP_W'(OP_ADD)) begin
      is_alu = 1'b1;
      alu_op = ALU_ADD;
    end else if (opcode == OP_W'(OP_SUB)) begin
      is_alu = 1'b1;
      alu_op = ALU_SUB;
    end else if (opcode == OP_W'(OP_MUL)) begin
      is_alu = 1'b1;
      alu_op = ALU_MUL;
    end else if (opcode == OP_W'(OP_DIV)) begin
      is_alu = 1'b1;
      alu_op = ALU_DIV;
    end else if (opcode == OP_W'(OP_JMP)) begin
      is_jmp = 1'b1;
    end else if (opcode == OP_W'(OP_HLT)) begin
      is_hlt = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator CPU with memory-ready handshake,
// halt, memory-timeout fault and a retired-instruction counter.
module control_sequencer
  import cpuf_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int OP_W     = 4,
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              mar_load,
  output logic              mar_sel,
  output logic              mem_rd,
  output logic              a_load,
  output logic              b_load,
  output logic              alu_en,
  output logic [1:0]        alu_op,
  output logic [ADDR_W-1:0] operand,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  // Opcode and operand fields must fit in one memory word
  if (DATA_W < OP_W + ADDR_W) begin : g_bad_width
    $error("control_sequencer: DATA_W must be >= OP_W + ADDR_W");
  end
  if (WAIT_MAX < 1) begin : g_bad_wait
    $error("control_sequencer: WAIT_MAX must be >= 1");
  end

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] ir_reg;
  logic [WC_W-1:0]   wait_cnt_reg;
  logic [CNT_W-1:0]  instr_cnt_reg;
  logic              retire;
  logic              in_wait;

  logic       dec_is_load, dec_is_ldb, dec_is_alu, dec_is_jmp, dec_is_hlt;
  logic [1:0] dec_alu_op;

  op_decoder #(.OP_W(OP_W)) u_op_decoder (
    .opcode  (ir_reg[DATA_W-1 -: OP_W]),
    .is_load (dec_is_load),
    .is_ldb  (dec_is_ldb),
    .is_alu  (dec_is_alu),
    .alu_op  (dec_alu_op),
    .is_jmp  (dec_is_jmp),
    .is_hlt  (dec_is_hlt)
  );

  assign in_wait = (state_reg == ST_FETCH_MEM) || (state_reg == ST_EXEC_MEM);

  // Next-state selection; retire marks the last cycle of each instruction
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      ST_FETCH_ADDR: if (run) state_next = ST_FETCH_MEM;
      ST_FETCH_MEM, ST_EXEC_MEM: begin
        // A ready in the final allowed wait cycle still completes the access
        if (mem_ready)
          state_next = (state_reg == ST_FETCH_MEM) ? ST_DECODE : ST_LOAD;
        else if (wait_cnt_reg == WC_W'(WAIT_MAX - 1))
          state_next = ST_FAULT;
      end
      ST_DECODE: begin
        if (dec_is_load)     state_next = ST_EXEC_ADDR;
        else if (dec_is_alu) state_next = ST_ALU;
        else if (dec_is_jmp) state_next = ST_JUMP;
        else if (dec_is_hlt) begin
          state_next = ST_HALT;
          retire     = 1'b1;
        end else begin
          state_next = ST_FETCH_ADDR;
          retire     = 1'b1;
        end
      end
      ST_EXEC_ADDR: state_next = ST_EXEC_MEM;
      ST_LOAD, ST_ALU, ST_JUMP: begin
        state_next = ST_FETCH_ADDR;
        retire     = 1'b1;
      end
      ST_HALT:  state_next = ST_HALT;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_FETCH_ADDR;
    endcase
  end

  // State, instruction register, wait timer and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_FETCH_ADDR;
      ir_reg        <= '0;
      wait_cnt_reg  <= '0;
      instr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_FETCH_MEM && mem_ready)
        ir_reg <= mem_rdata;
      // Timer only runs while stalled on memory, so it is zero on entry to any wait state
      if (in_wait && !mem_ready && state_next != ST_FAULT)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else
        wait_cnt_reg <= '0;
      if (retire)
        instr_cnt_reg <= instr_cnt_reg + 1'b1;
    end
  end

  // Control word decoded from the state register (run/reset gate only the fetch strobe)
  always_comb begin
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    mar_sel  = 1'b0;
    mem_rd   = 1'b0;
    a_load   = 1'b0;
    b_load   = 1'b0;
    alu_en   = 1'b0;
    alu_op   = ALU_ADD;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state_reg)
      ST_FETCH_ADDR: mar_load = run && !reset;
      ST_FETCH_MEM:  mem_rd   = 1'b1;
      ST_DECODE:     pc_inc   = 1'b1;
      ST_EXEC_ADDR: begin
        mar_load = 1'b1;
        mar_sel  = 1'b1;
      end
      ST_EXEC_MEM:   mem_rd = 1'b1;
      ST_LOAD: begin
        a_load = !dec_is_ldb;
        b_load = dec_is_ldb;
      end
      ST_ALU: begin
        alu_en = 1'b1;
        a_load = 1'b1;
        alu_op = dec_alu_op;
      end
      ST_JUMP:       pc_load = 1'b1;
      ST_HALT:       halted  = 1'b1;
      ST_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: ;
    endcase
  end

  assign operand   = ir_reg[ADDR_W-1:0];
  assign instr_cnt = instr_cnt_reg;

endmodule
